aes_spi_master: RTL

Parallel-to-serial front end for the bit-serial AES cores (`Encrypt` / `Decrypt`). It accepts one 128-bit block plus key over a valid/ready handshake and drives the core's `cs`/`miso` framing: data bits, then key bits, LSB first. It then waits out the core's compute window and collects the 128-bit result from `mosi` into a parallel output register. One instance sits directly upstream of each core and replaces testbench-style bit banging.

---
 rtl/aes_spi_pkg.sv | 24 ++
 rtl/aes_spi_master_if.sv | 47 ++++
 rtl/aes_spi_shreg.sv | 50 +++++
 rtl/aes_spi_master.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_spi_pkg.sv
// Shared definitions for the AES bit-serial front end.
// Holds the FSM state encoding, the fixed AES block width and a helper
// that sizes the bit counter so it can count a full load without wrapping.
package aes_spi_pkg;

    localparam int AES_BLOCK_BITS = 128;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_READ = 3'd4,
        ST_DONE = 3'd5
    } aes_spi_state_t;

    // Counter must reach 'bits' itself, hence the +1.
    function automatic int cnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

    localparam int AES_CNT_W = cnt_width(2 * AES_BLOCK_BITS);

endpackage

// File: rtl/aes_spi_master_if.sv
// Bus bundle between a request source/result sink and aes_spi_master,
// plus the serial link to the AES core.
//   master modport : the aes_spi_master side
//   slave  modport : the requester/consumer/core side
// Optional macro AES_SPI_MASTER_FINISHED_EN adds 'finished' (core -> master)
// and 'timeout' (master -> requester).
interface aes_spi_master_if
    import aes_spi_pkg::*;
#(
    parameter int BLOCK_BITS = AES_BLOCK_BITS,
    parameter int KEY_BITS   = 128
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BLOCK_BITS-1:0] in_data;
    logic [KEY_BITS-1:0]   in_key;
    logic                  out_valid;
    logic                  out_ready;
    logic [BLOCK_BITS-1:0] out_data;
    logic                  cs;
    logic                  miso;
    logic                  mosi;
    logic                  busy;
`ifdef AES_SPI_MASTER_FINISHED_EN
    logic                  finished;
    logic                  timeout;
`endif

    modport master (
        input  in_valid, in_data, in_key, out_ready, mosi,
`ifdef AES_SPI_MASTER_FINISHED_EN
        input  finished,
        output timeout,
`endif
        output in_ready, out_valid, out_data, cs, miso, busy
    );

    modport slave (
        output in_valid, in_data, in_key, out_ready, mosi,
`ifdef AES_SPI_MASTER_FINISHED_EN
        output finished,
        input  timeout,
`endif
        input  in_ready, out_valid, out_data, cs, miso, busy
    );

endinterface

// File: rtl/aes_spi_shreg.sv
// Loadable LSB-first shift register.
// Ports: clk, rst (async active-high); load/load_val parallel load;
// shift moves every bit one place toward bit 0; sample writes sin at idx;
// q is the register contents; sout is the LSB the register will hold after
// this edge, so a downstream flop can present it in the same cycle.
module aes_spi_shreg #(
    parameter int W     = 8,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W-1:0]     load_val,
    input  logic             shift,
    input  logic             sample,
    input  logic [IDX_W-1:0] idx,
    input  logic             sin,
    output logic [W-1:0]     q,
    output logic             sout
);
    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // Next contents: load beats shift beats indexed sample.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (shift) begin
            q_d = {1'b0, q_q[W-1:1]};
        end else if (sample) begin
            q_d[idx] = sin;
        end else begin
            q_d = q_q;
        end
    end

    // Register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign sout = q_d[0];

endmodule

// File: rtl/aes_spi_master.sv
// Parallel-to-serial front end for a bit-serial AES core.
// Accepts data+key over in_valid/in_ready, streams data then key LSB first
// on miso with cs high, holds cs low for the compute window, gives one
// setup cycle with cs high, then collects BLOCK_BITS result bits from mosi
// and presents them on out_data with out_valid until out_ready.
// Ports: clk, rst (async active-high), bus (aes_spi_master_if.master).
// Optional macro AES_SPI_MASTER_FINISHED_EN: the compute window ends early on
// 'finished'; WAIT_CYCLES becomes a timeout flagged on sticky 'timeout'.
module aes_spi_master
    import aes_spi_pkg::*;
#(
    parameter int BLOCK_BITS  = AES_BLOCK_BITS,
    parameter int KEY_BITS    = 128,
    parameter int WAIT_CYCLES = 26
) (
    input  logic             clk,
    input  logic             rst,
    aes_spi_master_if.master bus
);
    localparam int LOAD_BITS = BLOCK_BITS + KEY_BITS;
    localparam int CNT_W     = cnt_width(LOAD_BITS);
    localparam int RD_IDX_W  = $clog2(BLOCK_BITS);
    localparam int LD_IDX_W  = $clog2(LOAD_BITS);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_BITS - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(BLOCK_BITS - 1);

    aes_spi_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic cs_q, cs_d;
    logic miso_q, miso_d;
    logic in_ready_q, in_ready_d;
    logic out_valid_q, out_valid_d;
    logic busy_q, busy_d;
    logic accept_s;
    logic ld_sout_s;
    logic [LOAD_BITS-1:0]  ld_q_unused;
    logic [BLOCK_BITS-1:0] rd_q_s;
    logic                  rd_sout_unused;
`ifdef AES_SPI_MASTER_FINISHED_EN
    logic timeout_q, timeout_d;
    logic timeout_set_s;
`endif

    // in_ready_q is only ever high in IDLE, so it alone gates acceptance.
    assign accept_s = (state_q == ST_IDLE) && bus.in_valid && in_ready_q;

    // State and bit-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter; counter restarts at zero on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
`ifdef AES_SPI_MASTER_FINISHED_EN
        timeout_set_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (accept_s) state_d = ST_LOAD;
                else          state_d = ST_IDLE;
            end
            ST_LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_WAIT: begin
`ifdef AES_SPI_MASTER_FINISHED_EN
                if (bus.finished) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d       = ST_GAP;
                    cnt_d         = CNT_ZERO;
                    timeout_set_s = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
`else
                if (cnt_q == WAIT_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_WAIT;
                end
`endif
            end
            ST_GAP: begin
                state_d = ST_READ;
                cnt_d   = CNT_ZERO;
            end
            ST_READ: begin
                if (cnt_q == READ_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                cnt_d = CNT_ZERO;
                if (bus.out_ready) state_d = ST_IDLE;
                else               state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Outputs are decoded from the next state so the flops line up with it.
    always_comb begin
        cs_d        = (state_d == ST_LOAD) || (state_d == ST_GAP) || (state_d == ST_READ);
        miso_d      = (state_d == ST_LOAD) ? ld_sout_s : 1'b0;
        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
`ifdef AES_SPI_MASTER_FINISHED_EN
        if (accept_s)           timeout_d = 1'b0;
        else if (timeout_set_s) timeout_d = 1'b1;
        else                    timeout_d = timeout_q;
`endif
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q        <= 1'b0;
            miso_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef AES_SPI_MASTER_FINISHED_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            cs_q        <= cs_d;
            miso_q      <= miso_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
`ifdef AES_SPI_MASTER_FINISHED_EN
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Outgoing stream: key above data so bit 0 leaves first.
    aes_spi_shreg #(.W(LOAD_BITS), .IDX_W(LD_IDX_W)) u_load (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .load_val ({bus.in_key, bus.in_data}),
        .shift    (state_q == ST_LOAD),
        .sample   (1'b0),
        .idx      ({LD_IDX_W{1'b0}}),
        .sin      (1'b0),
        .q        (ld_q_unused),
        .sout     (ld_sout_s)
    );

    // Result collector; cleared on accept so a stale result never leaks.
    aes_spi_shreg #(.W(BLOCK_BITS), .IDX_W(RD_IDX_W)) u_read (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .load_val ({BLOCK_BITS{1'b0}}),
        .shift    (1'b0),
        .sample   (state_q == ST_READ),
        .idx      (cnt_q[RD_IDX_W-1:0]),
        .sin      (bus.mosi),
        .q        (rd_q_s),
        .sout     (rd_sout_unused)
    );

    assign bus.cs        = cs_q;
    assign bus.miso      = miso_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = rd_q_s;
`ifdef AES_SPI_MASTER_FINISHED_EN
    assign bus.timeout   = timeout_q;
`endif

endmodule
